// File: rtl/replica_pkg.sv
// Shared replica-wide parameters and the move-descriptor types used by the
// exchange, delta-distance and accept/reject stages.
package replica_pkg;

    localparam int city_num     = 16;
    localparam int city_num_log = 4;
    localparam int dist_bit     = 8;

    typedef enum logic {
        OR_OPT  = 1'b0,
        TWO_OPT = 1'b1
    } opt_command_t;

    typedef struct packed {
        opt_command_t            command;
        logic [city_num_log-1:0] K;
        logic [city_num_log-1:0] L;
        logic [city_num_log-1:0] M;
    } opt_t;

    // Next route position, wrapping the last position back to 0.
    function automatic logic [city_num_log-1:0] pos_inc(input logic [city_num_log-1:0] p);
        if (p == city_num_log'(city_num - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/delta_distance.sv
// Route-length delta of one or-opt / two-opt move: fetches the six (or four) endpoint
// cities, looks up the affected edges and sums added minus removed lengths.
// Two-opt support is compiled in only when DELTA_TWO_OPT_EN is defined.
module delta_distance
    import replica_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  opt_t                          opt,
    output logic                          busy,
    output logic [city_num_log-1:0]       ordering_addr,
    input  logic [city_num_log-1:0]       ordering_data,
    output logic [city_num_log-1:0]       dist_city_a,
    output logic [city_num_log-1:0]       dist_city_b,
    input  logic [dist_bit-1:0]           dist_data,
    output logic                          done,
    output logic signed [dist_bit+2:0]    delta
);

    localparam int ACC_W = dist_bit + 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOOKUP,
        DRAIN,
        DONE
    } state_t;

    state_t                    state_q;
    logic [4:0]                t_q;
    logic [city_num_log-1:0]   k_q, l_q, m_q;
    logic [city_num_log-1:0]   c_q [0:5];
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   delta_q;
    logic                      busy_q;
    logic                      done_q;
    logic [city_num_log-1:0]   addr_q;
    logic [city_num_log-1:0]   city_a_q;
    logic [city_num_log-1:0]   city_b_q;

`ifdef DELTA_TWO_OPT_EN
    logic                      two_q;
`else
    logic                      unused_command;
    assign unused_command = opt.command;
`endif

    logic [4:0]                n_reads;
    logic [2:0]                fetch_sel;
    logic [2:0]                cap_sel;
    logic [2:0]                pair_sel;
    logic [2:0]                term_sel;
    logic [2:0]                pair_a;
    logic [2:0]                pair_b;
    logic                      term_sub;
    logic [city_num_log-1:0]   fetch_pos;
    logic                      do_fetch;
    logic                      do_capture;
    logic                      do_accum;
    logic signed [ACC_W-1:0]   dist_ext;
    logic signed [ACC_W-1:0]   acc_sum;

    // t_q counts cycles since the accepted start; every pipeline step is a fixed
    // offset from it, so fetch, capture, lookup and accumulate overlap freely.
    always_comb begin
        n_reads = 5'd6;
`ifdef DELTA_TWO_OPT_EN
        if (two_q) begin
            n_reads = 5'd4;
        end
`endif
        fetch_sel = t_q[2:0];
        cap_sel   = 3'(t_q - 5'd2);
        pair_sel  = 3'(t_q - n_reads - 5'd1);
        term_sel  = 3'(t_q - n_reads - 5'd3);

        case (fetch_sel)
            3'd0:    fetch_pos = k_q;
            3'd1:    fetch_pos = pos_inc(k_q);
            3'd2:    fetch_pos = l_q;
            3'd3:    fetch_pos = pos_inc(l_q);
            3'd4:    fetch_pos = m_q;
            default: fetch_pos = pos_inc(m_q);
        endcase

        // Or-opt: remove (c0,c1),(c2,c3),(c4,c5); add (c0,c3),(c4,c1),(c2,c5).
        case (pair_sel)
            3'd0:    begin pair_a = 3'd0; pair_b = 3'd1; end
            3'd1:    begin pair_a = 3'd2; pair_b = 3'd3; end
            3'd2:    begin pair_a = 3'd4; pair_b = 3'd5; end
            3'd3:    begin pair_a = 3'd0; pair_b = 3'd3; end
            3'd4:    begin pair_a = 3'd4; pair_b = 3'd1; end
            default: begin pair_a = 3'd2; pair_b = 3'd5; end
        endcase
        term_sub = (term_sel < 3'd3);

`ifdef DELTA_TWO_OPT_EN
        // Two-opt: remove (c0,c1),(c2,c3); add (c0,c2),(c1,c3).
        if (two_q) begin
            case (pair_sel)
                3'd0:    begin pair_a = 3'd0; pair_b = 3'd1; end
                3'd1:    begin pair_a = 3'd2; pair_b = 3'd3; end
                3'd2:    begin pair_a = 3'd0; pair_b = 3'd2; end
                default: begin pair_a = 3'd1; pair_b = 3'd3; end
            endcase
            term_sub = (term_sel < 3'd2);
        end
`endif

        do_fetch   = (state_q == FETCH) && (t_q < n_reads);
        do_capture = (state_q != IDLE) && (t_q >= 5'd2) && (t_q <= n_reads + 5'd1);
        do_accum   = (state_q != IDLE) && (t_q >= n_reads + 5'd3);

        dist_ext = ACC_W'({3'b000, dist_data});
        acc_sum  = term_sub ? (acc_q - dist_ext) : (acc_q + dist_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            t_q      <= '0;
            k_q      <= '0;
            l_q      <= '0;
            m_q      <= '0;
`ifdef DELTA_TWO_OPT_EN
            two_q    <= 1'b0;
`endif
            acc_q    <= '0;
            delta_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            city_a_q <= '0;
            city_b_q <= '0;
            for (int i = 0; i < 6; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                t_q <= t_q + 5'd1;
            end
            if (do_fetch) begin
                addr_q <= fetch_pos;
            end
            if (do_capture) begin
                c_q[cap_sel] <= ordering_data;
            end
            if (state_q == LOOKUP) begin
                city_a_q <= c_q[pair_a];
                city_b_q <= c_q[pair_b];
            end
            if (do_accum) begin
                acc_q <= acc_sum;
            end

            case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        k_q     <= opt.K;
                        l_q     <= opt.L;
                        m_q     <= opt.M;
`ifdef DELTA_TWO_OPT_EN
                        two_q   <= (opt.command == TWO_OPT);
`endif
                        acc_q   <= '0;
                        t_q     <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (t_q == n_reads) begin
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (t_q == n_reads + n_reads) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                end
                DONE: begin
                    // The last term arrives this cycle, so delta takes the sum directly.
                    delta_q <= acc_sum;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign delta         = delta_q;
    assign ordering_addr = addr_q;
    assign dist_city_a   = city_a_q;
    assign dist_city_b   = city_b_q;

endmodule

// File: tb/tb_delta_distance.sv
// Directed bench for delta_distance: identity-style route memory, |a-b| distance model,
// hand-computed deltas for or-opt, two-opt, wrap, improving move, start-while-busy, reset.
module tb_delta_distance;
    import replica_pkg::*;

`ifdef DELTA_TWO_OPT_EN
    localparam int TWO_LAT = 11;
    localparam int D_K1L5  = 6;
    localparam int D_WRAP  = 0;
    localparam int D_IMPR  = -4;
`else
    localparam int TWO_LAT = 15;
    localparam int D_K1L5  = 14;
    localparam int D_WRAP  = -4;
    localparam int D_IMPR  = 10;
`endif

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start;
    opt_t                        opt;
    logic                        busy;
    logic [city_num_log-1:0]     ordering_addr;
    logic [city_num_log-1:0]     ordering_data;
    logic [city_num_log-1:0]     dist_city_a;
    logic [city_num_log-1:0]     dist_city_b;
    logic [dist_bit-1:0]         dist_data;
    logic                        done;
    logic signed [dist_bit+2:0]  delta;

    logic [city_num_log-1:0]     ord_mem [0:city_num-1];
    int                          last_addr [0:5];
    int                          errors = 0;
    int                          checks = 0;

    delta_distance dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opt           (opt),
        .busy          (busy),
        .ordering_addr (ordering_addr),
        .ordering_data (ordering_data),
        .dist_city_a   (dist_city_a),
        .dist_city_b   (dist_city_b),
        .dist_data     (dist_data),
        .done          (done),
        .delta         (delta)
    );

    always #5 clk = ~clk;

    // One-cycle read models for the exchange stage and the distance memory.
    always @(posedge clk) begin
        ordering_data <= ord_mem[ordering_addr];
        dist_data     <= (dist_city_a > dist_city_b) ? dist_bit'(dist_city_a - dist_city_b)
                                                     : dist_bit'(dist_city_b - dist_city_a);
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_opt(input opt_command_t cmd, input int k, input int l, input int m);
        opt.command = cmd;
        opt.K       = k[city_num_log-1:0];
        opt.L       = l[city_num_log-1:0];
        opt.M       = m[city_num_log-1:0];
    endtask

    task automatic run_move(input string tag, input opt_command_t cmd, input int k, input int l,
                            input int m, input int exp_delta, input int exp_lat);
        int done_cyc;
        @(negedge clk);
        start = 1'b1;
        set_opt(cmd, k, l, m);
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c <= 6) last_addr[c-1] = int'(ordering_addr);
            if (c == 1) chk({tag, " busy"}, int'(busy), 1);
            if (done) done_cyc = c;
        end
        chk({tag, " latency"}, done_cyc, exp_lat);
        chk({tag, " delta"}, int'(delta), exp_delta);
        $display("move %s K=%0d L=%0d M=%0d done_cycle=%0d delta=%0d", tag, k, l, m, done_cyc, int'(delta));
        @(negedge clk);
        chk({tag, " done pulse"}, int'(done), 0);
        chk({tag, " busy after"}, int'(busy), 0);
    endtask

    initial begin
        int dones;
        int done_cyc;
        int seen;

        for (int i = 0; i < city_num; i++) ord_mem[i] = city_num_log'(i);
        reset = 1'b1;
        start = 1'b0;
        set_opt(OR_OPT, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst delta", int'(delta), 0);
        chk("rst addr", int'(ordering_addr), 0);
        chk("rst city_a", int'(dist_city_a), 0);
        chk("rst city_b", int'(dist_city_b), 0);
        reset = 1'b0;

        // Or-opt K=2 L=4 M=7: removes 1+1+1, adds 3+4+4.
        run_move("oropt", OR_OPT, 2, 4, 7, 8, 15);
        chk("oropt addr0", last_addr[0], 2);
        chk("oropt addr1", last_addr[1], 3);
        chk("oropt addr2", last_addr[2], 4);
        chk("oropt addr3", last_addr[3], 5);
        chk("oropt addr4", last_addr[4], 7);
        chk("oropt addr5", last_addr[5], 8);

        run_move("twoopt", TWO_OPT, 1, 5, 9, D_K1L5, TWO_LAT);

        run_move("wrap", TWO_OPT, 3, 15, 9, D_WRAP, TWO_LAT);
        chk("wrap addr L+1", last_addr[3], 0);

        ord_mem[2] = 4'd4;
        ord_mem[4] = 4'd2;
        run_move("improve", TWO_OPT, 1, 4, 9, D_IMPR, TWO_LAT);
        ord_mem[2] = 4'd2;
        ord_mem[4] = 4'd4;

        // Starts sampled at edges 3 and 15 must be dropped; the one at edge 16 is taken.
        @(negedge clk);
        start = 1'b1;
        set_opt(OR_OPT, 2, 4, 7);
        @(negedge clk);
        start = 1'b0;
        set_opt(TWO_OPT, 1, 5, 9);
        dones = 0;
        done_cyc = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_cyc = c;
            end
            start = (c == 2 || c == 14 || c == 15);
        end
        chk("busystart done count", dones, 1);
        chk("busystart latency", done_cyc, 15);
        chk("busystart delta", int'(delta), 8);
        $display("move busystart first done_cycle=%0d delta=%0d", done_cyc, int'(delta));
        @(negedge clk);
        start = 1'b0;
        chk("busystart accepted", int'(busy), 1);
        done_cyc = -1;
        for (int c = 17; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (done) done_cyc = c;
        end
        chk("busystart second latency", done_cyc, 16 + TWO_LAT);
        chk("busystart second delta", int'(delta), D_K1L5);
        $display("move busystart second done_cycle=%0d delta=%0d", done_cyc, int'(delta));

        // Reset sampled at edge 9 of an or-opt run.
        @(negedge clk);
        start = 1'b1;
        set_opt(OR_OPT, 2, 4, 7);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset delta", int'(delta), 0);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midreset no done", seen, 0);
        $display("move midreset dones_after=%0d", seen);
        run_move("postreset", TWO_OPT, 1, 5, 9, D_K1L5, TWO_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delta_distance.md
# delta_distance

Computes the signed route-length change (delta) of one candidate or-opt or two-opt move for a single replica. Sits directly downstream of the exchange stage: drives that stage's ordering_addr read port, consumes the returned city number on ordering_data, and looks up city-pair distances from the shared distance memory. The result feeds the Metropolis accept/reject stage.

## Interface
- city_num (from replica_pkg): number of cities; route positions 0..city_num-1, wrap modulo city_num.
- city_num_log (from replica_pkg): width of a city number or position.
- dist_bit (from replica_pkg): width of one unsigned distance entry.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- opt  in  opt_t  move descriptor {command, K, L, M}; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- ordering_addr  out  city_num_log  route position to read from the exchange stage.
- ordering_data  in  city_num_log  city at the position driven one cycle earlier.
- dist_city_a  out  city_num_log  first city of the distance lookup.
- dist_city_b  out  city_num_log  second city of the distance lookup.
- dist_data  in  dist_bit  unsigned distance, valid one cycle after dist_city_a/b; symmetric.
- done  out  1  one-cycle pulse; delta is valid in this cycle.
- delta  out  dist_bit+3 signed  added minus removed edge lengths; held until next done.

## Operation
- FSM states: IDLE, FETCH, LOOKUP, DRAIN, DONE.
- IDLE: on start, latch opt, clear accumulator, go to FETCH.
- FETCH: drive positions one per cycle. Or-opt: K, K+1, L, L+1, M, M+1 (6 reads). Two-opt: K, K+1, L, L+1 (4 reads). Index +1 wraps: city_num-1 +1 -> 0. Capture ordering_data one cycle later into c0..c5.
- LOOKUP is entered after the last capture. It drives one pair per cycle and adds or subtracts dist_data one cycle later.
  - Or-opt pairs: -(c0,c1), -(c2,c3), -(c4,c5), +(c0,c3), +(c4,c1), +(c2,c5).
  - Two-opt pairs: -(c0,c1), -(c2,c3), +(c0,c2), +(c1,c3).
- DRAIN: accumulate the final dist_data.
- DONE: register delta, pulse done, return to IDLE.
- Arithmetic: dist_data is zero-extended to dist_bit+3 and accumulated in two's complement. Six terms cannot overflow.
- start while busy: ignored, with no queueing.
- Degenerate or inconsistent opt (e.g. M inside K+1..L): not checked. The formula is applied as-is; upstream guarantees validity.
- Reset at any point: FSM to IDLE, done is not pulsed, busy deasserts next edge.
- Reset values: busy 0, done 0, delta 0, ordering_addr 0, dist_city_a 0, dist_city_b 0.

## Timing
- Start is sampled at edge 0.
- Or-opt:
  - ordering_addr in cycles 1..6; captures 2..7.
  - dist_city pairs 8..13; accumulation 9..14.
  - done and delta in cycle 15. Latency 15.
- Two-opt:
  - ordering_addr 1..4; captures 2..5.
  - pairs 6..9; accumulation 7..10.
  - done in cycle 11. Latency 11.
- Earliest next accepted start is the cycle after done (back-to-back throughput 16 / 12 cycles).
- ordering_addr and dist_city_a/b are registered outputs. They hold their last value outside FETCH/LOOKUP.

## Configuration
- DELTA_TWO_OPT_EN defined: both commands are supported as above.
- DELTA_TWO_OPT_EN undefined:
  - The two-opt path, its pair table and its FSM branch are removed.
  - Every accepted start is treated as or-opt regardless of opt.command, with 15-cycle latency.

## Structure
- replica_pkg holds city_num, city_num_log, dist_bit, opt_command_t (OR_OPT, TWO_OPT) and opt_t {command, K, L, M}. The state enum and pair-select tables stay local to the module.
- No sub-module: the FSM, position counter, city capture registers and accumulator fit in one module.

## Test plan
- Common bench setup: city_num=16, identity ordering (o[i]=i), bench distance d(a,b)=|a-b|, one-cycle models for ordering and distance.
- Or-opt, identity ordering, K=2 L=4 M=7 -> done at cycle 15 with delta=+8; ordering_addr sequence 2,3,4,5,7,8.
- Two-opt, identity ordering, K=1 L=5 -> done at cycle 11 with delta=+6.
- Wrap: two-opt K=3 L=15 -> ordering_addr reads position 0 for L+1; delta=0.
- Improving move: ordering 0,1,4,3,2,5,6..15; two-opt K=1 L=4 -> delta=-4.
- start reasserted in cycles 3 and 15 of an or-opt run -> both ignored; exactly one done. A start at cycle 16 is accepted.
- reset asserted in cycle 9 of an or-opt run -> busy 0 and done never pulses. A following two-opt K=1 L=5 returns +6 with correct latency.
